cpu_sequencer: RTL

Sequential successor to the combinational instruction-phase controller of the 8-phase accumulator CPU. It owns the phase counter and a RUN/HALTED state machine, and decodes the same nine datapath strobes from opcode, phase and zero. It adds memory wait states, handled with a `mem_rdy` stall handshake, plus a parametrised bus-timeout error and a restartable halt. It sits between the instruction register/accumulator flags and the memory, PC, IR and accumulator load enables.

---
 rtl/cpu_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Phase sequencer for the 8-phase accumulator CPU: RUN/HALTED FSM, memory stall handshake, bus timeout.
// Strobes are combinational from phase/opcode/zero; stall points hold phase until mem_rdy, timeout raises bus_err.
module cpu_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int WAIT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    input  logic       go,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase,
    output logic       halted,
    output logic       bus_err
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam bit              TO_EN     = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [2:0]        phase_q, phase_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              bus_err_q, bus_err_nxt;
    logic              memop, is_sto, stall_pt;

    assign memop    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto   = (opcode == OP_STO);
    assign stall_pt = (phase_q == 3'd3) || ((phase_q == 3'd7) && (memop || is_sto));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            phase_q   <= 3'd0;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_q   <= phase_nxt;
            wait_cnt  <= wait_nxt;
            bus_err_q <= bus_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase_q;
        wait_nxt    = wait_cnt;
        bus_err_nxt = bus_err_q;
        sel         = 1'b0;
        rd          = 1'b0;
        ld_ir       = 1'b0;
        inc_pc      = 1'b0;
        halt        = 1'b0;
        ld_pc       = 1'b0;
        data_e      = 1'b0;
        ld_ac       = 1'b0;
        wr          = 1'b0;

        case (state)
            RUN: begin
                case (phase_q)
                    3'd0: sel = 1'b1;
                    3'd1: begin
                        sel = 1'b1;
                        rd  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        sel   = 1'b1;
                        rd    = 1'b1;
                        ld_ir = 1'b1;
                    end
                    3'd4: begin
                        inc_pc = 1'b1;
                        halt   = (opcode == OP_HLT);
                    end
                    3'd5: rd = memop;
                    3'd6: begin
                        rd     = memop;
                        inc_pc = (opcode == OP_SKZ) && zero;
                        ld_pc  = (opcode == OP_JMP);
                        data_e = is_sto;
                    end
                    default: begin
                        rd     = memop;
                        ld_ac  = memop;
                        ld_pc  = (opcode == OP_JMP);
                        data_e = is_sto;
                        wr     = is_sto;
                    end
                endcase

                // mem_rdy wins over a timeout landing in the same cycle
                if ((phase_q == 3'd4) && (opcode == OP_HLT)) begin
                    state_nxt = HALTED;
                    phase_nxt = 3'd0;
                    wait_nxt  = '0;
                end else if (stall_pt && !mem_rdy) begin
                    if (TO_EN && (wait_cnt == WAIT_LAST)) begin
                        state_nxt   = HALTED;
                        bus_err_nxt = 1'b1;
                        phase_nxt   = 3'd0;
                        wait_nxt    = '0;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    phase_nxt = phase_q + 3'd1;
                    wait_nxt  = '0;
                end
            end
            default: begin
                halt = 1'b1;
                if (go) begin
                    state_nxt   = RUN;
                    phase_nxt   = 3'd0;
                    wait_nxt    = '0;
                    bus_err_nxt = 1'b0;
                end
            end
        endcase
    end

    assign phase   = phase_q;
    assign halted  = (state == HALTED);
    assign bus_err = bus_err_q;

endmodule
